// File: rtl/cpu_seg_if.sv
// cpu_seg_if: CPU state taps into the display and the display's anode/segment drive back out.
interface cpu_seg_if;
    logic [1:0]  page_sel;
    logic [31:0] pc;
    logic [31:0] newpc;
    logic [4:0]  rs;
    logic [31:0] rs_data;
    logic [4:0]  rt;
    logic [31:0] rt_data;
    logic [31:0] alu_result;
    logic [31:0] db_data;
    logic [3:0]  pos_ctrl;
    logic [7:0]  num_ctrl;
    modport master (
        output page_sel, pc, newpc, rs, rs_data, rt, rt_data, alu_result, db_data,
        input  pos_ctrl, num_ctrl
    );
    modport slave (
        input  page_sel, pc, newpc, rs, rs_data, rt, rt_data, alu_result, db_data,
        output pos_ctrl, num_ctrl
    );
endinterface

// File: rtl/cpu_seg_display.sv
// cpu_seg_display: scans a 4-digit common-anode 7-segment display with a per-frame snapshot
// of one of four 16-bit CPU state views.
module cpu_seg_display #(
    parameter int SCAN_DIV = 100000
) (
    input logic clk,
    input logic RST,
    cpu_seg_if.slave bus
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [DW-1:0] div;
    logic [1:0]    idx, idx_n;
    logic [15:0]   snap, snap_n, view;
    logic [3:0]    nib;
    logic          tick;
    logic          unused_hi;
    assign tick = div == DW'(SCAN_DIV - 1);
    assign unused_hi = ^{bus.pc[31:8], bus.newpc[31:8], bus.rs_data[31:8],
                         bus.rt_data[31:8], bus.alu_result[31:8], bus.db_data[31:8]};
    always_comb begin
        view   = bus.page_sel == 2'd0 ? {bus.pc[7:0], bus.newpc[7:0]} :
                 bus.page_sel == 2'd1 ? {3'b000, bus.rs, bus.rs_data[7:0]} :
                 bus.page_sel == 2'd2 ? {3'b000, bus.rt, bus.rt_data[7:0]} :
                                        {bus.alu_result[7:0], bus.db_data[7:0]};
        idx_n  = idx + 2'd1;
        snap_n = idx == 2'd3 ? view : snap;
        nib    = snap_n[{idx_n, 2'b00} +: 4];
    end
    // Outputs are computed from the post-tick idx/snap so they change only on tick edges.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            div          <= '0;
            idx          <= 2'd3;
            snap         <= 16'h0000;
            bus.pos_ctrl <= 4'b1111;
            bus.num_ctrl <= 8'hFF;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                idx          <= idx_n;
                snap         <= snap_n;
                bus.pos_ctrl <= ~(4'b0001 << idx_n);
                bus.num_ctrl <= {idx_n != 2'd2, FONT[nib]};
            end
        end
    end
endmodule

// File: tb/tb_cpu_seg_display.sv
// tb_cpu_seg_display: directed checks of scan timing, frame snapshots, async reset and fast scan.
module tb_cpu_seg_display;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    always #5 clk = ~clk;
    cpu_seg_if bus();
    cpu_seg_if bus1();
    cpu_seg_display #(.SCAN_DIV(4)) dut (.clk(clk), .RST(RST), .bus(bus));
    cpu_seg_display #(.SCAN_DIV(1)) dut1 (.clk(clk), .RST(RST), .bus(bus1));

    task automatic do_reset();
        RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ep [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] en [4] = '{8'b1_1000000 & 8'h80, 8'b1_0110000, 8'b0_0011001, 8'b1_0110000};
        @(negedge clk);
        n_cmp++;
        if (bus.pos_ctrl !== 4'b1111) begin n_bad++; $display("FAIL reset_pos: got %b expected 1111", bus.pos_ctrl); end
        n_cmp++;
        if (bus.num_ctrl !== 8'hFF) begin n_bad++; $display("FAIL reset_num: got %h expected ff", bus.num_ctrl); end
        bus.page_sel = 2'd0;
        bus.pc = 32'h0000_0034;
        bus.newpc = 32'h0000_0038;
        RST = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.pos_ctrl !== 4'b1111 || bus.num_ctrl !== 8'hFF) begin
                n_bad++; $display("FAIL blank_after_release cyc %0d: got %b/%h expected 1111/ff", i, bus.pos_ctrl, bus.num_ctrl);
            end
        end
        for (int k = 0; k < 4; k++) begin
            repeat (k == 0 ? 1 : 4) @(negedge clk);
            n_cmp++;
            if (bus.pos_ctrl !== ep[k]) begin n_bad++; $display("FAIL frame0_pos d%0d: got %b expected %b", k, bus.pos_ctrl, ep[k]); end
            n_cmp++;
            if (bus.num_ctrl !== en[k]) begin n_bad++; $display("FAIL frame0_num d%0d: got %b expected %b", k, bus.num_ctrl, en[k]); end
        end
    endtask

    task automatic test_page_change();
        logic [7:0] en [8] = '{8'b1_0000000, 8'b1_0110000, 8'b0_0011001, 8'b1_0110000,
                               8'b1_0100001, 8'b1_1000110, 8'b0_0000011, 8'b1_0001000};
        for (int k = 0; k < 8; k++) begin
            repeat (4) @(negedge clk);
            n_cmp++;
            if (bus.num_ctrl !== en[k]) begin n_bad++; $display("FAIL page_change step %0d: got %b expected %b", k, bus.num_ctrl, en[k]); end
            if (k == 0) begin
                bus.page_sel = 2'd3;
                bus.alu_result = 32'hFFFF_FFAB;
                bus.db_data = 32'h1234_56CD;
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (12) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.pos_ctrl !== 4'b1011) begin n_bad++; $display("FAIL pre_reset_digit2: got %b expected 1011", bus.pos_ctrl); end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.pos_ctrl !== 4'b1111 || bus.num_ctrl !== 8'hFF) begin
            n_bad++; $display("FAIL async_reset: got %b/%h expected 1111/ff", bus.pos_ctrl, bus.num_ctrl);
        end
        repeat (3) @(negedge clk);
        RST = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.pos_ctrl !== 4'b1111 || bus.num_ctrl !== 8'hFF) begin
                n_bad++; $display("FAIL blank_after_mid_reset cyc %0d: got %b/%h expected 1111/ff", i, bus.pos_ctrl, bus.num_ctrl);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.pos_ctrl !== 4'b1110 || bus.num_ctrl !== 8'b1_0100001) begin
            n_bad++; $display("FAIL first_digit_after_mid_reset: got %b/%b expected 1110/10100001", bus.pos_ctrl, bus.num_ctrl);
        end
    endtask

    task automatic test_fast();
        logic [3:0] ep [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] en [4] = '{8'b1_1000000, 8'b1_1000000, 8'b0_0001110, 8'b1_1111001};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus1.pos_ctrl !== ep[k % 4] || bus1.num_ctrl !== en[k % 4]) begin
                n_bad++; $display("FAIL fast_scan step %0d: got %b/%b expected %b/%b", k, bus1.pos_ctrl, bus1.num_ctrl, ep[k % 4], en[k % 4]);
            end
        end
    endtask

    task automatic test_toggle();
        logic [15:0] v;
        logic [3:0]  ep;
        logic [7:0]  en;
        int t, ix, f;
        bus.page_sel = 2'd2;
        bus.rt = 5'd9;
        do_reset();
        bus.rt_data = {24'hABCDEF, 8'd3};
        for (int i = 1; i < 48; i++) begin
            @(negedge clk);
            if (i < 4) begin
                ep = 4'b1111;
                en = 8'hFF;
            end else begin
                t  = i / 4;
                ix = (t - 1) % 4;
                f  = 4 + 16 * ((t - 1) / 4);
                v  = {8'h09, 8'((f - 1) * 7 + 3)};
                ep = ~(4'b0001 << ix);
                en = {ix != 2, font[v[ix*4 +: 4]]};
            end
            n_cmp++;
            if (bus.pos_ctrl !== ep || bus.num_ctrl !== en) begin
                n_bad++; $display("FAIL toggle cyc %0d: got %b/%b expected %b/%b", i, bus.pos_ctrl, bus.num_ctrl, ep, en);
            end
            bus.rt_data = {24'hABCDEF, 8'(i * 7 + 3)};
        end
    endtask

    task automatic test_onehot();
        do_reset();
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            n_cmp++;
            if (i < 4) begin
                if (bus.pos_ctrl !== 4'b1111) begin n_bad++; $display("FAIL onehot_blank cyc %0d: got %b expected 1111", i, bus.pos_ctrl); end
            end else if ($countones(~bus.pos_ctrl) != 1 || $isunknown(bus.pos_ctrl)) begin
                n_bad++; $display("FAIL onehot cyc %0d: got %b expected one low bit", i, bus.pos_ctrl);
            end
            bus.page_sel = 2'($urandom_range(0, 3));
            bus.pc = $urandom;
        end
    endtask

    initial begin
        bus.page_sel = 2'd0; bus.pc = '0; bus.newpc = '0; bus.rs = '0; bus.rs_data = '0;
        bus.rt = '0; bus.rt_data = '0; bus.alu_result = '0; bus.db_data = '0;
        bus1.page_sel = 2'd1; bus1.pc = '0; bus1.newpc = '0; bus1.rs = 5'd31; bus1.rs_data = 32'hFFFF_FF00;
        bus1.rt = '0; bus1.rt_data = '0; bus1.alu_result = '0; bus1.db_data = '0;
        test_reset();
        test_page_change();
        test_reset_mid();
        test_fast();
        test_toggle();
        test_onehot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
